c499_sec_locked: RTL and testbench
==================================

Name: c499_sec_locked

Overview:
- Registered, logic-locked version of the ISCAS-85 c499 function: a 32-bit single-error-correcting (SEC) decoder.
- Takes a 32-bit data word, 8 check bits and a check-enable bit `r`, and returns the corrected data word one clock later.
- A 31-bit key input unlocks it. Any key other than `KEY_CORRECT` corrupts the output deterministically.
- Sits in the datapath directly after a storage or link stage that delivers `id`/`ic` pairs.

Parameters:
- `KEY_CORRECT`, default 31'h2A5F3C96: unlocking key value.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: qualifies `id`, `ic`, `r` and `key` in the current cycle.
- `id`  in  32: received data word. Bit i sits in byte b = i/8 at position p = i%8.
- `ic`  in  8: received check bits.
- `r`  in  1: check-bit enable. When 0, all `ic` bits are treated as 0.
- `key`  in  31: lock key.
- `out_valid`  out  1: asserted for one cycle when `od` is updated.
- `od`  out  32: corrected, key-masked data word.

Behaviour:
- Reset: `od` = 0 and `out_valid` = 0 immediately on `rst` assertion, independent of `clk`. Reset asserted mid-operation discards any in-flight word.
- Latency is 1 cycle. When `in_valid` is 1 at a rising edge, `od` is loaded and `out_valid` = 1 for that following cycle.
- When `in_valid` is 0, `od` holds its value and `out_valid` = 0.
- All logic between input and `od` register is combinational. There is no other state.
- Position code `code(p)`, 4 bits, all odd weight:
  - p0 = 0001, p1 = 0010, p2 = 0100, p3 = 1000
  - p4 = 0111, p5 = 1011, p6 = 1101, p7 = 1110
- Gated check bits: `g[j] = ic[j] & r`.
- Syndrome, bits 0..3: `s[b]` = XOR of `id[8b+7:8b]` XOR `g[b]`, for b = 0..3.
- Syndrome, bits 4..7: `s[4+k]` = XOR of all `id[i]` where bit k of `code(i%8)` is 1, XOR `g[4+k]`, for k = 0..3.
- Correction flag: `e[i] = (s[3:0] == onehot(i/8)) && (s[7:4] == code(i%8))`.
  - At most one `e[i]` is set.
  - Syndromes that match no data bit (check-bit-only errors, double errors) produce no correction.
- Corrected word: `c[i] = id[i] ^ e[i]`.
- Lock mask:
  - `d = key ^ KEY_CORRECT` (31 bits).
  - `m[30:0] = d`.
  - `m[31]` = OR-reduce of `d`.
- Output: `od <= c ^ m`. With the correct key `m` = 0 and `od` = `c`.
- `key` is sampled with the data and is not latched separately, so key changes take effect on the next accepted word.
- Back-to-back `in_valid` is fully supported: one word per cycle, no stall.

Optional Feature:
- Macro `C499_SYNDROME_OUT_EN`.
- When defined, adds two outputs:
  - `syn  out  8`: registered `s`, reset to 0, loaded alongside `od`.
  - `err  out  1`: registered flag, high when `s != 0` and no `e[i]` is set (uncorrectable or check-bit error), reset to 0.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Correct key, r=1, id=0x00000000, ic=0x00 → next cycle `od` = 0x00000000, `out_valid` = 1.
- Correct key, r=1, id=0x00000001, ic=0x00 → s=0x11, bit 0 corrected → `od` = 0x00000000.
- Correct key, id=0, ic=0x11:
  - r=1 → `od` = 0x00000001.
  - r=0 → `od` = 0x00000000.
- Correct key, r=1, id=0x00000003, ic=0 → s=0x30, no match → `od` = 0x00000003. With the macro on, `err` = 1 and `syn` = 0x30.
- key=31'h7FFFFFFF, id=0, ic=0, r=1 → `od` = 0xD5A0C369.
- Apply id=0xFFFF0000 with `in_valid`, then assert `rst` between clock edges → `od` = 0 and `out_valid` = 0 immediately, before the next clock edge. After release, `od` holds 0 until the next `in_valid`.

Source files
------------

// File: rtl/c499_sec_locked.sv
// Registered, key-locked c499 32-bit SEC decoder.
// Optional syn/err outputs when C499_SYNDROME_OUT_EN is defined.
module c499_sec_locked #(
  parameter logic [30:0] KEY_CORRECT = 31'h2A5F3C96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] id,
  input  logic [7:0]  ic,
  input  logic        r,
  input  logic [30:0] key,
  output logic        out_valid,
  output logic [31:0] od
`ifdef C499_SYNDROME_OUT_EN
  ,
  output logic [7:0]  syn,
  output logic        err
`endif
);

  function automatic logic [3:0] pos_code(input logic [2:0] p);
    logic [3:0] c;
    c = 4'b0000;
    case (p)
      3'd0: c = 4'b0001;
      3'd1: c = 4'b0010;
      3'd2: c = 4'b0100;
      3'd3: c = 4'b1000;
      3'd4: c = 4'b0111;
      3'd5: c = 4'b1011;
      3'd6: c = 4'b1101;
      3'd7: c = 4'b1110;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] byte_sel(input logic [1:0] b);
    logic [3:0] o;
    o = 4'b0000;
    o[b] = 1'b1;
    return o;
  endfunction

  logic [7:0]  g;
  logic [7:0]  s;
  logic [31:0] e;
  logic [31:0] c;
  logic [30:0] d;
  logic [31:0] m;

  assign g = ic & {8{r}};

  // Byte parities on s[3:0], position-code parities on s[7:4].
  always_comb begin
    s = g;
    for (int i = 0; i < 32; i++) begin
      if (id[i]) begin
        s[3:0] = s[3:0] ^ byte_sel(2'(i / 8));
        s[7:4] = s[7:4] ^ pos_code(3'(i % 8));
      end
    end
  end

  always_comb begin
    e = '0;
    for (int i = 0; i < 32; i++) begin
      e[i] = (s[3:0] == byte_sel(2'(i / 8)))
          && (s[7:4] == pos_code(3'(i % 8)));
    end
  end

  assign c = id ^ e;

  // A wrong key flips bits in a key-dependent but fixed pattern.
  assign d = key ^ KEY_CORRECT;
  assign m = {|d, d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      od        <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) od <= c ^ m;
    end
  end

`ifdef C499_SYNDROME_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn <= '0;
      err <= 1'b0;
    end else if (in_valid) begin
      syn <= s;
      err <= (|s) && !(|e);
    end
  end
`endif

endmodule

// File: tb/tb_c499_sec_locked.sv
// Randomized self-checking bench for c499_sec_locked.
// Reference decoder searches for the single-bit flip matching the syndrome.
module tb_c499_sec_locked;

  localparam logic [30:0] KC = 31'h2A5F3C96;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] id;
  logic [7:0]  ic;
  logic        r;
  logic [30:0] key;
  logic        out_valid;
  logic [31:0] od;
`ifdef C499_SYNDROME_OUT_EN
  logic [7:0]  syn;
  logic        err;
`endif

  int vecs = 0;
  int errs = 0;

  logic [3:0] codes [8] = '{4'h1, 4'h2, 4'h4, 4'h8,
                            4'h7, 4'hB, 4'hD, 4'hE};

  c499_sec_locked dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .id(id),
    .ic(ic),
    .r(r),
    .key(key),
    .out_valid(out_valid),
    .od(od)
`ifdef C499_SYNDROME_OUT_EN
    ,
    .syn(syn),
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_syn(logic [31:0] dw, logic [7:0] cb,
                                       logic rr);
    logic [7:0] s;
    s = rr ? cb : 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (dw[i]) begin
        s[i / 8] = ~s[i / 8];
        s[7:4] = s[7:4] ^ codes[i % 8];
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] m_dec(logic [31:0] dw, logic [7:0] cb,
                                        logic rr);
    logic [7:0]  s;
    logic [31:0] o;
    s = m_syn(dw, cb, rr);
    o = dw;
    for (int i = 0; i < 32; i++) begin
      if (s != 8'h00 && m_syn(32'(1) << i, 8'h00, 1'b0) == s)
        o[i] = ~o[i];
    end
    return o;
  endfunction

  function automatic logic [31:0] m_mask(logic [30:0] k);
    logic [30:0] dd;
    dd = k ^ KC;
    return {|dd, dd};
  endfunction

  function automatic logic [31:0] m_od(logic [31:0] dw, logic [7:0] cb,
                                       logic rr, logic [30:0] k);
    return m_dec(dw, cb, rr) ^ m_mask(k);
  endfunction

  task automatic drive(logic [31:0] dw, logic [7:0] cb, logic rr,
                       logic [30:0] k);
    @(negedge clk);
    id = dw;
    ic = cb;
    r = rr;
    key = k;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    id = $urandom;
    ic = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    id = '0;
    ic = '0;
    r = 1'b0;
    key = KC;
    #1;
    vecs++;
    if (od !== 32'h0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset: od=%h ov=%b want 0/0", od, out_valid);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] want [6];
    logic [31:0] dws [6];
    logic [7:0]  cbs [6];
    logic        rrs [6];
    logic [30:0] ks [6];
    dws = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h3, 32'h0};
    cbs = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h00, 8'h00};
    rrs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ks  = '{KC, KC, KC, KC, KC, 31'h7FFFFFFF};
    want = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h3, 32'hD5A0C369};
    for (int t = 0; t < 6; t++) begin
      drive(dws[t], cbs[t], rrs[t], ks[t]);
      vecs++;
      if (od !== want[t] || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL directed%0d: od=%h ov=%b want %h/1",
                 t, od, out_valid, want[t]);
      end
`ifdef C499_SYNDROME_OUT_EN
      if (t == 4) begin
        vecs++;
        if (syn !== 8'h30 || err !== 1'b1) begin
          errs++;
          $display("FAIL uncorrectable: syn=%h err=%b want 30/1", syn, err);
        end
      end
`endif
    end
    idle();
  endtask

  task automatic test_hold();
    logic [31:0] prev;
    drive(32'h12345678, 8'h5A, 1'b1, KC);
    prev = od;
    idle();
    @(posedge clk);
    #1;
    vecs++;
    if (od !== prev || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL hold: od=%h ov=%b want %h/0", od, out_valid, prev);
    end
  endtask

  task automatic test_random();
    logic [31:0] dw;
    logic [7:0]  cb;
    logic        rr;
    logic [30:0] k;
    logic [31:0] exp;
    for (int n = 0; n < 200; n++) begin
      dw = $urandom;
      rr = 1'b1;
      k = ($urandom_range(0, 3) == 0) ? 31'($urandom) : KC;
      case ($urandom_range(0, 3))
        0: cb = m_syn(dw, 8'h00, 1'b1);
        1: begin
          cb = m_syn(dw, 8'h00, 1'b1);
          dw[$urandom_range(0, 31)] ^= 1'b1;
        end
        2: begin
          cb = m_syn(dw, 8'h00, 1'b1);
          cb[$urandom_range(0, 7)] ^= 1'b1;
        end
        default: begin
          cb = 8'($urandom);
          rr = 1'($urandom);
        end
      endcase
      exp = m_od(dw, cb, rr, k);
      drive(dw, cb, rr, k);
      vecs++;
      if (od !== exp || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL random%0d: id=%h ic=%h r=%b od=%h want %h",
                 n, dw, cb, rr, od, exp);
      end
`ifdef C499_SYNDROME_OUT_EN
      vecs++;
      if (syn !== m_syn(dw, cb, rr) ||
          err !== (m_syn(dw, cb, rr) != 0 && m_dec(dw, cb, rr) == dw)) begin
        errs++;
        $display("FAIL random_syn%0d: syn=%h err=%b", n, syn, err);
      end
`endif
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] dw;
    logic [7:0]  cb;
    logic [31:0] exp;
    logic [31:0] last;
    last = '0;
    for (int n = 0; n < 10; n++) begin
      dw = $urandom;
      cb = m_syn(dw, 8'h00, 1'b1);
      dw[n] ^= 1'b1;
      dw[31 - n] ^= (n > 6);
      exp = m_od(dw, cb, 1'b1, KC);
      drive(dw, cb, 1'b1, KC);
      last = exp;
      vecs++;
      if (od !== exp || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL b2b%0d: od=%h ov=%b want %h/1", n, od, out_valid, exp);
      end
    end
    idle();
    @(posedge clk);
    #1;
    vecs++;
    if (od !== last || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end: od=%h ov=%b want %h/0", od, out_valid, last);
    end
  endtask

  task automatic test_async_reset();
    drive(32'hFFFF0000, 8'h00, 1'b1, KC);
    vecs++;
    if (od !== 32'hFFFF0000 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst: od=%h ov=%b want ffff0000/1", od, out_valid);
    end
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (od !== 32'h0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL async_rst: od=%h ov=%b want 0/0", od, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (od !== 32'h0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_rst: od=%h ov=%b want 0/0", od, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
